// File: rtl/decode_scoreboard_if.sv
// Decode/issue bundle: instruction in, writeback, issue register out.
interface decode_scoreboard_if #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8
);
   localparam int RW = $clog2(NREG);

   logic             in_valid;
   logic             in_ready;
   logic [RW-1:0]    in_rs;
   logic [RW-1:0]    in_rt;
   logic [RW-1:0]    in_rd;
   logic             in_use_rs;
   logic             in_use_rt;
   logic             in_wr_rd;
   logic [WIDTH-1:0] in_ctrl;
   logic             wb_valid;
   logic [RW-1:0]    wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sr1;
   logic [WIDTH-1:0] out_sr2;
   logic [RW-1:0]    out_rd;
   logic             out_wr_rd;
   logic [WIDTH-1:0] out_ctrl;
   logic             flush;
   logic             hazard_stall;

   modport slave (
      input  in_valid, in_rs, in_rt, in_rd,
      input  in_use_rs, in_use_rt, in_wr_rd, in_ctrl,
      input  wb_valid, wb_rd, wb_data,
      input  out_ready, flush,
      output in_ready, out_valid, out_sr1, out_sr2,
      output out_rd, out_wr_rd, out_ctrl, hazard_stall
   );

   modport master (
      output in_valid, in_rs, in_rt, in_rd,
      output in_use_rs, in_use_rt, in_wr_rd, in_ctrl,
      output wb_valid, wb_rd, wb_data,
      output out_ready, flush,
      input  in_ready, out_valid, out_sr1, out_sr2,
      input  out_rd, out_wr_rd, out_ctrl, hazard_stall
   );
endinterface

// File: rtl/decode_scoreboard.sv
// Decode-stage register file with pending-write scoreboard and issue register.
module decode_scoreboard #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   parameter int CNTW  = 2
) (
   input logic clk,
   input logic reset_n,
   decode_scoreboard_if.slave bus
);
   localparam int RW = $clog2(NREG);
   localparam logic [CNTW-1:0] CMAX = '1;
   localparam logic [CNTW-1:0] CONE = CNTW'(1);

   logic [WIDTH-1:0] rf_q  [NREG];
   logic [WIDTH-1:0] rf_d  [NREG];
   logic [CNTW-1:0]  cnt_q [NREG];
   logic [CNTW-1:0]  cnt_d [NREG];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sr1_q, sr1_d;
   logic [WIDTH-1:0] sr2_q, sr2_d;
   logic [RW-1:0]    rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [WIDTH-1:0] ctrl_q, ctrl_d;

   logic             wb_hit_rs, wb_hit_rt, wb_hit_rd;
   logic             haz_rs, haz_rt, haz_rd;
   logic             hazard, ready, issue, fl_dec;
   logic [WIDTH-1:0] rd_a, rd_b;

   // Saturating-free net update; hazard logic prevents overflow on increment.
   function automatic logic [CNTW-1:0] cnt_next(
      input logic [CNTW-1:0] c,
      input logic            inc,
      input logic [1:0]      dec
   );
      logic [CNTW+1:0] s;
      logic [CNTW+1:0] d;
      s = {2'b00, c} + {{(CNTW+1){1'b0}}, inc};
      d = {{CNTW{1'b0}}, dec};
      if (s < d) return '0;
      s = s - d;
      return s[CNTW-1:0];
   endfunction

   always_comb begin
      wb_hit_rs = bus.wb_valid && (bus.wb_rd == bus.in_rs);
      wb_hit_rt = bus.wb_valid && (bus.wb_rd == bus.in_rt);
      wb_hit_rd = bus.wb_valid && (bus.wb_rd == bus.in_rd);
      rd_a = wb_hit_rs ? bus.wb_data : rf_q[bus.in_rs];
      rd_b = wb_hit_rt ? bus.wb_data : rf_q[bus.in_rt];
      haz_rs = bus.in_use_rs && (cnt_q[bus.in_rs] != '0)
               && !((cnt_q[bus.in_rs] == CONE) && wb_hit_rs);
      haz_rt = bus.in_use_rt && (cnt_q[bus.in_rt] != '0)
               && !((cnt_q[bus.in_rt] == CONE) && wb_hit_rt);
      haz_rd = bus.in_wr_rd && (cnt_q[bus.in_rd] == CMAX) && !wb_hit_rd;
      hazard = bus.in_valid && (haz_rs || haz_rt || haz_rd);
      ready  = !hazard && (!out_valid_q || bus.out_ready) && !bus.flush;
      issue  = bus.in_valid && ready;
      fl_dec = bus.flush && out_valid_q && wr_q && !bus.out_ready;
   end

   always_comb begin
      rf_d = rf_q;
      if (bus.wb_valid) rf_d[bus.wb_rd] = bus.wb_data;
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_next(
            cnt_q[i],
            issue && bus.in_wr_rd && (bus.in_rd == RW'(i)),
            {1'b0, bus.wb_valid && (bus.wb_rd == RW'(i))}
            + {1'b0, fl_dec && (rd_q == RW'(i))});
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      sr1_d  = sr1_q;
      sr2_d  = sr2_q;
      rd_d   = rd_q;
      wr_d   = wr_q;
      ctrl_d = ctrl_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (issue) begin
         out_valid_d = 1'b1;
         sr1_d  = rd_a;
         sr2_d  = rd_b;
         rd_d   = bus.in_rd;
         wr_d   = bus.in_wr_rd;
         ctrl_d = bus.in_ctrl;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         sr1_q  <= '0;
         sr2_q  <= '0;
         rd_q   <= '0;
         wr_q   <= 1'b0;
         ctrl_q <= '0;
      end else begin
         rf_q        <= rf_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         sr1_q  <= sr1_d;
         sr2_q  <= sr2_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         ctrl_q <= ctrl_d;
      end
   end

   assign bus.in_ready     = ready;
   assign bus.hazard_stall = hazard;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_sr1      = sr1_q;
   assign bus.out_sr2      = sr2_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_wr_rd    = wr_q;
   assign bus.out_ctrl     = ctrl_q;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard with an issue-order scoreboard.
module tb_decode_scoreboard;
   typedef struct packed {
      logic [15:0] sr1;
      logic [15:0] sr2;
      logic [2:0]  rd;
      logic        wr;
      logic [15:0] ctrl;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   nvec = 0;
   int   nerr = 0;
   exp_t exp_q[$];

   decode_scoreboard_if #(.WIDTH(16), .NREG(8)) bus ();

   decode_scoreboard #(.WIDTH(16), .NREG(8), .CNTW(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [2:0] rs, rt, rd,
                      input logic urs, urt, wr, input logic [15:0] ctrl);
      bus.in_valid  = v;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_use_rs = urs;
      bus.in_use_rt = urt;
      bus.in_wr_rd  = wr;
      bus.in_ctrl   = ctrl;
   endtask

   task automatic wbk(input logic v, input logic [2:0] r,
                      input logic [15:0] d);
      bus.wb_valid = v;
      bus.wb_rd    = r;
      bus.wb_data  = d;
   endtask

   task automatic push(input logic [15:0] a, b, input logic [2:0] rd,
                       input logic wr, input logic [15:0] ctrl);
      exp_t e;
      e.sr1 = a; e.sr2 = b; e.rd = rd; e.wr = wr; e.ctrl = ctrl;
      exp_q.push_back(e);
   endtask

   task automatic comb(input logic hz, input logic rdy);
      #1;
      chk("hazard_stall", 64'(bus.hazard_stall), 64'(hz));
      chk("in_ready", 64'(bus.in_ready), 64'(rdy));
   endtask

   // One clock: consume/compare a departing entry, then step past the edge.
   task automatic cyc();
      exp_t o, e;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
         o.sr1 = bus.out_sr1; o.sr2 = bus.out_sr2; o.rd = bus.out_rd;
         o.wr = bus.out_wr_rd; o.ctrl = bus.out_ctrl;
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(o), 64'hDEAD);
         end else begin
            e = exp_q.pop_front();
            chk("sb_issue", 64'(o), 64'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      wbk(0, 0, 0);
      bus.out_ready = 1'b1;
      bus.flush = 1'b0;
      cyc(); cyc();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_sr1", 64'(bus.out_sr1), 64'd0);
      chk("rst_out_sr2", 64'(bus.out_sr2), 64'd0);
      chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
      chk("rst_out_wr_rd", 64'(bus.out_wr_rd), 64'd0);
      chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
      reset_n = 1'b1;
      comb(0, 1);
      cyc();

      // RAW on r3 resolved by same-cycle writeback bypass
      drv(1, 0, 0, 3, 0, 0, 1, 16'h0ADD);
      comb(0, 1); push(0, 0, 3, 1, 16'h0ADD); cyc();
      drv(1, 3, 0, 6, 1, 0, 0, 16'h000B);
      comb(1, 0); cyc();
      comb(1, 0); cyc();
      wbk(1, 3, 16'h1234);
      comb(0, 1); push(16'h1234, 0, 6, 0, 16'h000B); cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0); wbk(0, 0, 0); cyc();

      // Double-source bypass on r4
      wbk(1, 4, 16'hBEEF);
      drv(1, 4, 4, 0, 1, 1, 0, 16'h0042);
      comb(0, 1); push(16'hBEEF, 16'hBEEF, 0, 0, 16'h0042); cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0); wbk(0, 0, 0); cyc();

      // Counter saturation on r5
      for (int i = 0; i < 3; i++) begin
         drv(1, 3, 0, 5, 1, 0, 1, 16'(16'h0500 + i));
         comb(0, 1); push(16'h1234, 0, 5, 1, 16'(16'h0500 + i)); cyc();
      end
      drv(1, 3, 0, 5, 1, 0, 1, 16'h0503);
      comb(1, 0); cyc();
      wbk(1, 5, 16'h5555);
      comb(0, 1); push(16'h1234, 0, 5, 1, 16'h0503); cyc();
      wbk(0, 0, 0);
      drv(1, 3, 0, 5, 1, 0, 1, 16'h0504);
      comb(1, 0); cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0); cyc();

      // Backpressure hold for five cycles
      bus.out_ready = 1'b0;
      drv(1, 4, 0, 1, 1, 0, 0, 16'h039A);
      comb(0, 1); push(16'hBEEF, 0, 1, 0, 16'h039A); cyc();
      drv(1, 3, 0, 7, 1, 0, 0, 16'h039B);
      for (int i = 0; i < 5; i++) begin
         comb(0, 0);
         chk("hold_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_sr1", 64'(bus.out_sr1), 64'(exp_q[0].sr1));
         chk("hold_ctrl", 64'(bus.out_ctrl), 64'(exp_q[0].ctrl));
         cyc();
      end
      bus.out_ready = 1'b1;
      comb(0, 1); push(16'h1234, 0, 7, 0, 16'h039B); cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0); cyc();

      // Flush of a held write to r2 releases its counter
      bus.out_ready = 1'b0;
      drv(1, 0, 0, 2, 0, 0, 1, 16'h0040);
      comb(0, 1); push(0, 0, 2, 1, 16'h0040); cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      bus.flush = 1'b1;
      comb(0, 0);
      void'(exp_q.pop_front());
      cyc();
      bus.flush = 1'b0;
      chk("flush_valid", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b1;
      drv(1, 2, 0, 0, 1, 0, 0, 16'h0041);
      comb(0, 1); push(0, 0, 0, 0, 16'h0041); cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0); cyc();

      // Asynchronous reset with a held write and pending counters
      bus.out_ready = 1'b0;
      drv(1, 0, 0, 6, 0, 0, 1, 16'h0066);
      comb(0, 1); push(0, 0, 6, 1, 16'h0066); cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_wr_rd", 64'(bus.out_wr_rd), 64'd0);
      chk("arst_ctrl", 64'(bus.out_ctrl), 64'd0);
      chk("arst_sr1", 64'(bus.out_sr1), 64'd0);
      exp_q.delete();
      wbk(1, 1, 16'hFFFF);
      cyc();
      reset_n = 1'b1;
      wbk(0, 0, 0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drv(1, 3'(i), 3'(i), 3'(i), 1, 1, 0, 16'(i));
         comb(0, 1); push(0, 0, 3'(i), 0, 16'(i)); cyc();
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameter WIDTH, default 16, data word width.
REQ-002 Parameter NREG, default 8, architectural register count; index width RW = clog2(NREG).
REQ-003 Parameter CNTW, default 2, per-register pending-write counter width; saturation value is 2^CNTW-1.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decoded instruction present.
REQ-007 in_ready  out  1  stage accepts instruction this cycle.
REQ-008 in_rs, in_rt, in_rd  in  RW each  source A, source B and destination indices.
REQ-009 in_use_rs, in_use_rt, in_wr_rd  in  1 each  source-read and destination-write enables.
REQ-010 in_ctrl  in  WIDTH  control word, passed through unchanged.
REQ-011 wb_valid  in  1  writeback strobe.
REQ-012 wb_rd  in  RW  writeback register index.
REQ-013 wb_data  in  WIDTH  writeback data.
REQ-014 out_valid  out  1  issue register holds an instruction.
REQ-015 out_ready  in  1  downstream accepts.
REQ-016 out_sr1, out_sr2  out  WIDTH each  operand values.
REQ-017 out_rd  out  RW  destination index.
REQ-018 out_wr_rd  out  1  destination-write flag.
REQ-019 out_ctrl  out  WIDTH  registered control word.
REQ-020 flush  in  1  discard held instruction.
REQ-021 hazard_stall  out  1  stall caused by a scoreboard hazard, not by backpressure.

Function
REQ-022 The block SHALL hold an NREG x WIDTH register file, written on wb_valid at the clock edge.
REQ-023 Operand reads SHALL bypass: if wb_valid and wb_rd equals a used source index in the same cycle, wb_data SHALL be captured instead of the array value.
REQ-024 The block SHALL keep one CNTW-bit pending counter per register.
REQ-025 A source hazard SHALL exist when a used source's counter is nonzero, except when the counter is 1 and wb_valid with wb_rd equal to that source occurs in the same cycle.
REQ-026 A destination hazard SHALL exist when in_wr_rd is set and the in_rd counter is saturated, unless a wb_valid to in_rd occurs in the same cycle.
REQ-027 hazard_stall SHALL equal in_valid AND (source hazard OR destination hazard).
REQ-028 in_ready SHALL equal NOT hazard_stall AND (NOT out_valid OR out_ready) AND NOT flush.
REQ-029 Issue (in_valid AND in_ready) SHALL load the issue register with operands, in_rd, in_wr_rd and in_ctrl, and SHALL set out_valid; latency is one cycle.
REQ-030 On issue with in_wr_rd set, the in_rd counter SHALL increment; on wb_valid the wb_rd counter SHALL decrement; both to the same register in one cycle SHALL leave it unchanged.
REQ-031 A decrement of a zero counter SHALL leave it at zero.
REQ-032 Output handshake: out_valid and held values SHALL remain stable until out_valid AND out_ready, then clear unless a new issue occurs in the same cycle.
REQ-033 flush SHALL clear out_valid next cycle and block issue; if the held entry has out_wr_rd set and is not being accepted that cycle, its out_rd counter SHALL decrement (combined with any wb_valid decrement to the same register as a single decrement by two, floored at zero).
REQ-034 out_sr1, out_sr2, out_rd, out_wr_rd and out_ctrl SHALL be registered; all outputs glitch-free of combinational paths from out_ready except in_ready.

Reset
REQ-035 reset_n low SHALL asynchronously clear out_valid, out_wr_rd, all pending counters, out_sr1, out_sr2, out_rd, out_ctrl and every register-file entry to zero.
REQ-036 Reset asserted mid-operation SHALL discard the held instruction and all pending state; no write in the reset cycle SHALL take effect.

Verification
REQ-037 Issue ADD rd=3 wr; next cycle issue rs=3 -> hazard_stall=1, in_ready=0 until wb_valid wb_rd=3 wb_data=0x1234, then issue same cycle with out_sr1=0x1234 next cycle.
REQ-038 CNTW=2: issue four writes to r5 without writeback -> fourth stalls (counter=3); wb_valid wb_rd=5 in stall cycle -> fourth issues, counter stays 3.
REQ-039 out_ready=0 with out_valid=1 -> in_ready=0, hazard_stall=0, outputs held for 5 cycles; out_ready=1 -> next instruction loads.
REQ-040 Held entry wr r2 (counter 1), flush=1 -> out_valid=0 next cycle, r2 counter 0, dependent rs=2 issues without stall.
REQ-041 reset_n pulled low asynchronously mid-cycle with out_valid=1 and counters nonzero -> out_valid=0 and all counters 0 immediately, r0..r7 read 0.
REQ-042 wb_valid wb_rd=4 wb_data=0xBEEF with issue rs=4 rt=4 (counter 0) -> out_sr1=out_sr2=0xBEEF.
